// File: rtl/gpr_port_ctrl.sv
// rtl/gpr_port_ctrl.sv - GPR file access controller: write-port arbitration, read sequencing, write forwarding
module gpr_port_ctrl #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w0_valid,
    output logic        w0_ready,
    input  logic [4:0]  w0_addr,
    input  logic [31:0] w0_data,
    input  logic        w1_valid,
    output logic        w1_ready,
    input  logic [4:0]  w1_addr,
    input  logic [31:0] w1_data,
    input  logic        rd_req,
    output logic        rd_ready,
    input  logic [4:0]  rd_rs,
    input  logic [4:0]  rd_rt,
    output logic        rd_valid,
    output logic [31:0] rd_a,
    output logic [31:0] rd_b,
    output logic [4:0]  gpr_rs,
    output logic [4:0]  gpr_rt,
    input  logic [31:0] gpr_busa,
    input  logic [31:0] gpr_busb,
    output logic [4:0]  gpr_rw,
    output logic [31:0] gpr_busw,
    output logic        gpr_regwr
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    // Starvation counter for the load writeback requester
    logic [3:0]  wait1_q, wait1_d;

    // Write issue registers (drive the register-file write port directly)
    logic        regwr_q, regwr_d;
    logic [4:0]  rw_q, rw_d;
    logic [31:0] busw_q, busw_d;

    // Read pipeline: stage 1 = address presented to the file, stage 2 = data returning
    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic        hit_a_q, hit_a_d;
    logic        hit_b_q, hit_b_d;
    logic        zero_a_q, zero_a_d;
    logic        zero_b_q, zero_b_d;
    logic [31:0] fwd_a_q, fwd_a_d;
    logic [31:0] fwd_b_q, fwd_b_d;

    logic override;
    logic grant0;
    logic grant1;
    logic accept;

    // Arbitration: w0 wins unless w1 has waited MAX_WAIT cycles and is still asking
    always_comb begin
        override = (wait1_q == MAX_W);
        w0_ready = reset & ~(override & w1_valid);
        w1_ready = reset & (~w0_valid | override);
        rd_ready = reset;
        grant0   = w0_valid & w0_ready;
        grant1   = w1_valid & w1_ready;
        accept   = rd_req & rd_ready;
    end

    // Next-state for the starvation counter and the write issue stage
    always_comb begin
        wait1_d = 4'd0;
        if (w1_valid & ~w1_ready) begin
            wait1_d = (wait1_q == MAX_W) ? wait1_q : wait1_q + 4'd1;
        end

        regwr_d = 1'b0;
        rw_d    = rw_q;
        busw_d  = busw_q;
        if (grant0) begin
            regwr_d = (w0_addr != 5'd0);
            rw_d    = w0_addr;
            busw_d  = w0_data;
        end else if (grant1) begin
            regwr_d = (w1_addr != 5'd0);
            rw_d    = w1_addr;
            busw_d  = w1_data;
        end
    end

    // Next-state for the read pipeline; forward capture happens as the file samples the address
    always_comb begin
        s1_valid_d = accept;
        s2_valid_d = s1_valid_q;
        rs_d       = accept ? rd_rs : rs_q;
        rt_d       = accept ? rd_rt : rt_q;
        hit_a_d    = hit_a_q;
        hit_b_d    = hit_b_q;
        zero_a_d   = zero_a_q;
        zero_b_d   = zero_b_q;
        fwd_a_d    = fwd_a_q;
        fwd_b_d    = fwd_b_q;
        if (s1_valid_q) begin
            // The write committing on this edge is invisible to the file's registered read
            hit_a_d  = regwr_q & (rw_q == rs_q) & (rs_q != 5'd0);
            hit_b_d  = regwr_q & (rw_q == rt_q) & (rt_q != 5'd0);
            zero_a_d = (rs_q == 5'd0);
            zero_b_d = (rt_q == 5'd0);
            fwd_a_d  = busw_q;
            fwd_b_d  = busw_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait1_q    <= 4'd0;
            regwr_q    <= 1'b0;
            rw_q       <= 5'd0;
            busw_q     <= 32'd0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            hit_a_q    <= 1'b0;
            hit_b_q    <= 1'b0;
            zero_a_q   <= 1'b0;
            zero_b_q   <= 1'b0;
            fwd_a_q    <= 32'd0;
            fwd_b_q    <= 32'd0;
        end else begin
            wait1_q    <= wait1_d;
            regwr_q    <= regwr_d;
            rw_q       <= rw_d;
            busw_q     <= busw_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            hit_a_q    <= hit_a_d;
            hit_b_q    <= hit_b_d;
            zero_a_q   <= zero_a_d;
            zero_b_q   <= zero_b_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
        end
    end

    // Output mux: r0 reads as zero, then forwarded data, then file data
    always_comb begin
        gpr_regwr = regwr_q;
        gpr_rw    = rw_q;
        gpr_busw  = busw_q;
        gpr_rs    = rs_q;
        gpr_rt    = rt_q;
        rd_valid  = s2_valid_q;
        rd_a      = zero_a_q ? 32'd0 : (hit_a_q ? fwd_a_q : gpr_busa);
        rd_b      = zero_b_q ? 32'd0 : (hit_b_q ? fwd_b_q : gpr_busb);
    end

endmodule

// File: tb/tb_gpr_port_ctrl.sv
// tb/tb_gpr_port_ctrl.sv - self-checking bench for gpr_port_ctrl
module tb_gpr_port_ctrl;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w0_valid = 1'b0;
    logic        w0_ready;
    logic [4:0]  w0_addr = 5'd0;
    logic [31:0] w0_data = 32'd0;
    logic        w1_valid = 1'b0;
    logic        w1_ready;
    logic [4:0]  w1_addr = 5'd0;
    logic [31:0] w1_data = 32'd0;
    logic        rd_req = 1'b0;
    logic        rd_ready;
    logic [4:0]  rd_rs = 5'd0;
    logic [4:0]  rd_rt = 5'd0;
    logic        rd_valid;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [4:0]  gpr_rs;
    logic [4:0]  gpr_rt;
    logic [31:0] gpr_busa = 32'd0;
    logic [31:0] gpr_busb = 32'd0;
    logic [4:0]  gpr_rw;
    logic [31:0] gpr_busw;
    logic        gpr_regwr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    gpr_port_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_rs(rd_rs), .rd_rt(rd_rt),
        .rd_valid(rd_valid), .rd_a(rd_a), .rd_b(rd_b),
        .gpr_rs(gpr_rs), .gpr_rt(gpr_rt), .gpr_busa(gpr_busa), .gpr_busb(gpr_busb),
        .gpr_rw(gpr_rw), .gpr_busw(gpr_busw), .gpr_regwr(gpr_regwr)
    );

    initial forever #5 clk = ~clk;

    // Register file: registered reads return the value held before this edge's write
    logic [31:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    always @(posedge clk) begin
        if (gpr_regwr && gpr_rw != 5'd0) mem[gpr_rw] <= gpr_busw;
        gpr_busa <= (gpr_rs == 5'd0) ? 32'd0 : mem[gpr_rs];
        gpr_busb <= (gpr_rt == 5'd0) ? 32'd0 : mem[gpr_rt];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers, one pending commit, expected read results
    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] b;
    } rd_t;
    rd_t         q[$];
    logic [31:0] arch [32];
    initial for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    int          cyc = 0;
    int          mwait = 0;
    bit          pend_v = 1'b0;
    logic [4:0]  pend_a = 5'd0;
    logic [31:0] pend_d = 32'd0;
    bit          exp_regwr = 1'b0;

    function automatic logic m_ready0();
        return reset && !((mwait == MAX_WAIT) && w1_valid);
    endfunction

    function automatic logic m_ready1();
        return reset && (!w0_valid || (mwait == MAX_WAIT));
    endfunction

    function automatic logic [31:0] view(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (pend_v && pend_a == r) return pend_d;
        return arch[r];
    endfunction

    always @(posedge clk) begin
        bit  g0, g1, r1;
        rd_t e;
        cyc++;
        if (!reset) begin
            pend_v    = 1'b0;
            exp_regwr = 1'b0;
            mwait     = 0;
            q.delete();
        end else begin
            if (pend_v) arch[pend_a] = pend_d;
            g0 = w0_valid && m_ready0();
            g1 = w1_valid && m_ready1();
            r1 = m_ready1();
            pend_v = 1'b0;
            if (g0 && w0_addr != 5'd0) begin
                pend_v = 1'b1; pend_a = w0_addr; pend_d = w0_data;
            end else if (g1 && w1_addr != 5'd0) begin
                pend_v = 1'b1; pend_a = w1_addr; pend_d = w1_data;
            end
            exp_regwr = pend_v;
            if (rd_req) begin
                e.due = cyc + 1;
                e.a   = view(rd_rs);
                e.b   = view(rd_rt);
                q.push_back(e);
            end
            if (w1_valid && !r1) mwait = (mwait < MAX_WAIT) ? mwait + 1 : MAX_WAIT;
            else mwait = 0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            chk("w0_ready", {31'd0, w0_ready}, {31'd0, m_ready0()});
            chk("w1_ready", {31'd0, w1_ready}, {31'd0, m_ready1()});
            chk("rd_ready", {31'd0, rd_ready}, {31'd0, reset});
            chk("gpr_regwr", {31'd0, gpr_regwr}, {31'd0, exp_regwr});
            if (exp_regwr) begin
                chk("gpr_rw", {27'd0, gpr_rw}, {27'd0, pend_a});
                chk("gpr_busw", gpr_busw, pend_d);
            end
            ev = (q.size() > 0) && (q[0].due == cyc);
            chk("rd_valid", {31'd0, rd_valid}, {31'd0, ev});
            if (ev) begin
                chk("rd_a", rd_a, q[0].a);
                chk("rd_b", rd_b, q[0].b);
                void'(q.pop_front());
            end
        end
    end

    task automatic go();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every request asserted
        w0_valid = 1; w0_addr = 5'd3; w0_data = 32'h33;
        w1_valid = 1; w1_addr = 5'd4; w1_data = 32'h44;
        rd_req = 1; rd_rs = 5'd1; rd_rt = 5'd2;
        go();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_w0_ready", {31'd0, w0_ready}, 32'd0);
            chk("t1_w1_ready", {31'd0, w1_ready}, 32'd0);
            chk("t1_rd_ready", {31'd0, rd_ready}, 32'd0);
            chk("t1_regwr", {31'd0, gpr_regwr}, 32'd0);
            chk("t1_rd_valid", {31'd0, rd_valid}, 32'd0);
            go();
        end
        reset = 1; #1;
        chk("t1_w0_ready_rel", {31'd0, w0_ready}, 32'd1);
        chk("t1_rd_ready_rel", {31'd0, rd_ready}, 32'd1);
        chk("t1_w1_ready_rel", {31'd0, w1_ready}, 32'd0);
        go();
        w0_valid = 0; w1_valid = 0; rd_req = 0;
        go(); go(); go();

        // Write r5 then read it back
        w0_valid = 1; w0_addr = 5'd5; w0_data = 32'hDEADBEEF; #1;
        chk("t2_w0_ready", {31'd0, w0_ready}, 32'd1);
        go();
        w0_valid = 0;
        chk("t2_regwr", {31'd0, gpr_regwr}, 32'd1);
        chk("t2_rw", {27'd0, gpr_rw}, 32'd5);
        chk("t2_busw", gpr_busw, 32'hDEADBEEF);
        go();
        chk("t2_regwr_off", {31'd0, gpr_regwr}, 32'd0);
        go();
        rd_req = 1; rd_rs = 5'd5; rd_rt = 5'd0;
        go();
        rd_req = 0;
        chk("t2_rd_valid_early", {31'd0, rd_valid}, 32'd0);
        go();
        chk("t2_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("t2_rd_a", rd_a, 32'hDEADBEEF);
        chk("t2_rd_b", rd_b, 32'd0);
        go();
        chk("t2_rd_valid_pulse", {31'd0, rd_valid}, 32'd0);

        // Same-edge hazard on r7
        w1_valid = 1; w1_addr = 5'd7; w1_data = 32'h11; #1;
        chk("t3_w1_ready", {31'd0, w1_ready}, 32'd1);
        go();
        w1_valid = 0;
        go(); go();
        rd_req = 1; rd_rs = 5'd7; rd_rt = 5'd7;
        go();
        w1_valid = 1; w1_addr = 5'd7; w1_data = 32'h22;
        go();
        w1_valid = 0;
        chk("t3_before_a", rd_a, 32'h11);
        chk("t3_before_b", rd_b, 32'h11);
        go();
        rd_req = 0;
        chk("t3_same_a", rd_a, 32'h22);
        chk("t3_same_b", rd_b, 32'h22);
        go();
        chk("t3_after_a", rd_a, 32'h22);
        go();

        // Starvation override
        w0_valid = 1; w0_addr = 5'd10; w1_valid = 1; w1_addr = 5'd11; w1_data = 32'hB0;
        for (int c = 1; c <= 6; c++) begin
            w0_data = 32'hA0 + 32'(c); #1;
            chk("t4_w0_ready", {31'd0, w0_ready}, (c != 5) ? 32'd1 : 32'd0);
            chk("t4_w1_ready", {31'd0, w1_ready}, (c == 5) ? 32'd1 : 32'd0);
            go();
        end
        w0_valid = 0; w1_valid = 0;
        go(); go();
        rd_req = 1; rd_rs = 5'd10; rd_rt = 5'd11;
        go();
        rd_req = 0;
        go();
        chk("t4_r10", rd_a, 32'hA6);
        chk("t4_r11", rd_b, 32'hB0);
        go();

        // Zero register
        w0_valid = 1; w0_addr = 5'd0; w0_data = 32'hFFFFFFFF;
        rd_req = 1; rd_rs = 5'd0; rd_rt = 5'd0; #1;
        chk("t5_w0_ready", {31'd0, w0_ready}, 32'd1);
        go();
        w0_valid = 0; rd_req = 0;
        chk("t5_regwr", {31'd0, gpr_regwr}, 32'd0);
        go();
        chk("t5_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("t5_rd_a", rd_a, 32'd0);
        chk("t5_rd_b", rd_b, 32'd0);
        go();

        // Reset while a read and a write are in flight
        rd_req = 1; rd_rs = 5'd5; rd_rt = 5'd7;
        w0_valid = 1; w0_addr = 5'd9; w0_data = 32'h99;
        go();
        rd_req = 0; w0_valid = 0; reset = 0; #1;
        chk("t6_rd_ready_rst", {31'd0, rd_ready}, 32'd0);
        go();
        chk("t6_no_valid0", {31'd0, rd_valid}, 32'd0);
        go();
        chk("t6_no_valid1", {31'd0, rd_valid}, 32'd0);
        reset = 1; rd_req = 1; rd_rs = 5'd5; rd_rt = 5'd9;
        go();
        rd_req = 0;
        chk("t6_lat1", {31'd0, rd_valid}, 32'd0);
        go();
        chk("t6_valid", {31'd0, rd_valid}, 32'd1);
        chk("t6_rd_a", rd_a, 32'hDEADBEEF);
        chk("t6_rd_b_dropped", rd_b, 32'd0);
        go();

        // Mixed traffic on a few registers, checked by the model only
        for (int i = 0; i < 40; i++) begin
            w0_valid = (i % 3) != 0; w0_addr = 5'(i % 4); w0_data = 32'h1000 + 32'(i);
            w1_valid = (i % 5) != 4; w1_addr = 5'((i + 1) % 4); w1_data = 32'h2000 + 32'(i);
            rd_req = (i % 7) != 6; rd_rs = 5'((i + 2) % 4); rd_rt = 5'(i % 4);
            go();
        end
        w0_valid = 0; w1_valid = 0; rd_req = 0;
        for (int i = 0; i < 4; i++) go();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_port_ctrl.md
Name: gpr_port_ctrl

Overview:
- Access controller for the 32x32 general-purpose register file (two registered read ports, one write port, r0 hard-wired to zero).
- Shares the single write port between two writeback requesters: w0 (ALU, priority) and w1 (memory load).
- Sequences register-file reads so that each read returns data that includes every write granted at or before the read's acceptance edge.
- Forwards writes that commit on the same edge the register file samples its read ports.

Parameters:
MAX_WAIT, 4, consecutive stalled cycles of w1 after which w1 overrides w0 (1..15).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
w0_valid  in  1  ALU writeback request
w0_ready  out  1  w0 grant; transfer when w0_valid&w0_ready at clk edge
w0_addr  in  5  destination register
w0_data  in  32  write data
w1_valid  in  1  load writeback request
w1_ready  out  1  w1 grant
w1_addr  in  5  destination register
w1_data  in  32  write data
rd_req  in  1  read request; accepted when rd_req&rd_ready at clk edge
rd_ready  out  1  read accept
rd_rs  in  5  source register A
rd_rt  in  5  source register B
rd_valid  out  1  one-cycle pulse, rd_a/rd_b valid
rd_a  out  32  read data A
rd_b  out  32  read data B
gpr_rs  out  5  register-file read address A (registered)
gpr_rt  out  5  register-file read address B (registered)
gpr_busa  in  32  register-file read data A (registered inside file)
gpr_busb  in  32  register-file read data B
gpr_rw  out  5  register-file write address (registered)
gpr_busw  out  32  register-file write data (registered)
gpr_regwr  out  1  register-file write enable (registered)

Behaviour:
- Reset (reset=0, asynchronous): gpr_regwr=0, gpr_rw=0, gpr_busw=0, gpr_rs=0, gpr_rt=0, rd_valid=0, starvation counter=0, read pipeline flushed. w0_ready=w1_ready=rd_ready=0 while reset=0.
- Reset mid-operation: in-flight reads are dropped and never produce rd_valid. Granted but uncommitted writes are dropped.
- Write arbitration, combinational from valids and counter:
  - override = (wait1 == MAX_WAIT).
  - w0_ready = !(override & w1_valid).
  - w1_ready = !w0_valid | override.
  - Never both granted in one cycle.
- Starvation counter wait1:
  - +1 each edge with w1_valid & !w1_ready, saturating at MAX_WAIT.
  - Cleared on a w1 grant or when w1_valid=0.
- Write issue:
  - A grant at edge T registers gpr_regwr=1, gpr_rw=addr, gpr_busw=data. The register file commits at edge T+1.
  - No grant at T gives gpr_regwr=0 for the following cycle.
  - Grant with addr=0: request is consumed, gpr_regwr stays 0.
- Read pipeline, fully pipelined, one accept per cycle:
  - rd_ready=1 whenever reset=1.
  - Accept at edge R0: gpr_rs/gpr_rt <= rd_rs/rd_rt. The register file samples at R1.
  - rd_valid=1 during the cycle after R1 (2-cycle latency, back-to-back reads give back-to-back pulses).
- Forwarding:
  - At R1, if gpr_regwr=1 and gpr_rw matches gpr_rs (resp. gpr_rt), capture gpr_busw into a forward register with a hit flag.
  - rd_a = hit_a ? fwd_a : gpr_busa, and likewise for rd_b.
  - Net semantics: a read sees writes granted at or before its accept edge, and never sees writes granted afterwards.
- Address 0: rd_a/rd_b forced to 0 when the corresponding address is 0. Forwarding is never applied for r0.
- Simultaneous w0/w1 to the same address: only the granted one is written; the other waits.
- rd_rs == rd_rt: both outputs carry identical, identically forwarded data.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with all requests high -> all ready=0, gpr_regwr=0, rd_valid=0. Release reset -> w0_ready=rd_ready=1.
2. Write then read: w0 grant r5=0xDEADBEEF at edge T -> gpr_regwr=1, gpr_rw=5, gpr_busw=0xDEADBEEF in cycle T..T+1. Read r5 accepted at T+3 -> rd_valid at T+5 with rd_a=0xDEADBEEF.
3. Same-edge hazard: r7 holds 0x11; w1 grant r7=0x22 and read rs=rt=7 accepted on the same edge -> rd_a=rd_b=0x22. Read accepted one edge before the grant -> 0x11.
4. Starvation: w0_valid and w1_valid held high, MAX_WAIT=4 -> w0 granted 4 cycles, w1_ready=1 in cycle 5, w0 resumes in cycle 6.
5. Zero register: w0 grant r0=0xFFFFFFFF -> gpr_regwr stays 0, w0 consumed. Read rs=0, rt=0 -> rd_a=rd_b=0.
6. Reset mid-flight: read accepted at R0, reset=0 asserted before R1 -> no rd_valid. First read after release returns the correct register-file contents with 2-cycle latency.
